fifo_stream_reader: RTL and testbench

Read-side client for the synchronous FIFO. It drains words through the FIFO read port (`rd_en`, `empty`, registered `data_out` with one-cycle read latency) and presents them downstream as a valid/ready stream at full throughput. A 3-entry holding buffer absorbs the FIFO read latency, so no combinational path exists from `m_ready` to `fifo_rd_en`. It sits between the FIFO and any stream consumer, such as a serializer or bus master.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/rd_hold_buf.sv | 46 ++++
 rtl/fifo_stream_reader.sv | 58 +++++
 tb/tb_fifo_stream_reader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side client: buffer depth, derived widths
// and the mod-3 pointer increment.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BUF_DEPTH      = 3;
  localparam int OCC_W          = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W          = $clog2(BUF_DEPTH);
  localparam int CREDIT_W       = OCC_W + 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/rd_hold_buf.sv
// 3-entry circular holding buffer absorbing the FIFO read latency.
// Clear drops every buffered word and beats a same-cycle push.
module rd_hold_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [OCC_W-1:0]      o_occ,
  output logic [DATA_WIDTH-1:0] o_head_data
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [OCC_W-1:0]      r_occ;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ  <= '0;
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_occ  <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (i_pop) r_head <= ptr_inc(r_head);
      r_occ <= r_occ + OCC_W'(i_push) - OCC_W'(i_pop);
    end
  end

  assign o_occ       = r_occ;
  assign o_head_data = r_mem[r_head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream at full rate; read
// issue depends only on registered credit, never on the downstream ready.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_flush,
  input  logic                   i_fifo_empty,
  input  logic [DATA_WIDTH-1:0]  i_fifo_data,
  output logic                   o_fifo_rd_en,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output logic [DATA_WIDTH-1:0]  o_m_data,
  output logic [COUNT_WIDTH-1:0] o_word_count
);

  logic                   r_pending;
  logic [COUNT_WIDTH-1:0] r_word_count;
  logic [OCC_W-1:0]       w_occ;
  logic [CREDIT_W-1:0]    w_credit;
  logic                   w_pop;

  // Buffered plus in-flight words may never exceed the buffer depth.
  assign w_credit     = CREDIT_W'(w_occ) + CREDIT_W'(r_pending);
  assign o_fifo_rd_en = i_en & ~i_fifo_empty & ~i_flush & ~i_rst &
                        (w_credit < CREDIT_W'(BUF_DEPTH));
  assign o_m_valid    = (w_occ != '0);
  assign w_pop        = o_m_valid & i_m_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending    <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_pending <= o_fifo_rd_en;
      if (w_pop) r_word_count <= r_word_count + 1'b1;
    end
  end

  rd_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_flush),
    .i_push      (r_pending),
    .i_push_data (i_fifo_data),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head_data (o_m_data)
  );

  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: behavioural FIFO in front, directed
// scenarios drive it, a negedge monitor checks every accepted word.
module tb_fifo_stream_reader;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          m_ready = 1'b0;
  logic          rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] wc;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush),
    .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data), .o_fifo_rd_en(rd_en),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_word_count(wc)
  );

  // Behavioural FIFO: registered data_out, empty reflects count after each edge.
  logic [DW-1:0] fq[$];
  logic          w_en = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          f_clr = 1'b0;
  int            rdcnt = 0;
  int            outst = 0;

  always @(posedge clk) begin
    if (rd_en) begin
      rdcnt <= rdcnt + 1;
      if (fq.size() > 0) fifo_data <= fq.pop_front();
    end
    if (f_clr) fq.delete();
    if (w_en) fq.push_back(w_data);
    fifo_empty <= (fq.size() == 0);
    if (rst || flush) outst <= 0;
    else outst <= outst + int'(rd_en) - int'(m_valid && m_ready);
  end

  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int fails = 0;
  int credit_viol = 0;
  int exp_wc = 0;

  // Monitor: compare accepted words, enforce hold-while-stalled, watch credit.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word actual=%0h required=none", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            fails++;
            $display("FAIL word actual=%0h required=%0h", m_data, e);
          end
        end
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          fails++;
          $display("FAIL stall_hold actual=%0b/%0h required=1/%0h", m_valid, m_data, prev_data);
        end
      end
      prev_stall = m_valid & ~m_ready & ~rst & ~flush;
      prev_data  = m_data;
      if (outst > 3) credit_viol++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [DW-1:0] v, input bit add_exp);
    w_en = 1'b1; w_data = v;
    if (add_exp) exp_q.push_back(v);
    step(1);
    w_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || int'(wc) != exp_wc) && n < 500) begin
      step(1); n++;
    end
    chk({nm, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_wc"}, 64'(wc), 64'(exp_wc));
  endtask

  initial begin
    int n;
    int base;
    int written;

    // Reset state
    step(2);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_wc", 64'(wc), 64'd0);
    rst = 1'b0;
    step(1);

    // Stream 1..8 at full rate
    for (int i = 1; i <= 8; i++) push(DW'(i), 1'b1);
    step(1);
    m_ready = 1'b1; base = rdcnt; en = 1'b1; #1;
    chk("t1_rden", 64'(rd_en), 64'd1);
    n = 0;
    while (!m_valid && n < 10) begin step(1); n++; end
    chk("t1_latency", 64'(n), 64'd2);
    n = 0;
    while (wc != 16'd8 && n < 20) begin step(1); n++; end
    chk("t1_gapless", 64'(n), 64'd8);
    chk("t1_reads", 64'(rdcnt - base), 64'd8);
    exp_wc = 8;
    drain("t1");
    chk("t1_idle", 64'(m_valid), 64'd0);

    // Backpressure: 10 stalled cycles allow exactly 3 reads
    en = 1'b0; m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i), 1'b1);
    step(1);
    base = rdcnt; en = 1'b1;
    step(10);
    chk("t2_reads", 64'(rdcnt - base), 64'd3);
    chk("t2_valid", 64'(m_valid), 64'd1);
    chk("t2_head", 64'(m_data), 64'h1);
    m_ready = 1'b1;
    exp_wc += 8;
    drain("t2");

    // Flush with occ=2, pending=1: A1..A3 dropped, drain resumes at A4
    en = 1'b0; m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(DW'(32'hA0 + i), 1'b0);
    step(1);
    base = rdcnt; en = 1'b1;
    n = 0;
    while (rdcnt - base < 3 && n < 10) begin step(1); n++; end
    chk("t3_setup", 64'(rdcnt - base), 64'd3);
    chk("t3_pre_valid", 64'(m_valid), 64'd1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("t3_valid", 64'(m_valid), 64'd0);
    chk("t3_wc", 64'(wc), 64'(exp_wc));
    exp_q.push_back(32'hA4);
    exp_q.push_back(32'hA5);
    m_ready = 1'b1;
    exp_wc += 2;
    drain("t3");

    // en dropped in steady state (occ=1, pending=1): two words still delivered
    en = 1'b0;
    for (int i = 1; i <= 6; i++) push(DW'(32'h10 + i), 1'b0);
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h12);
    step(1);
    base = rdcnt; en = 1'b1;
    n = 0;
    while (!m_valid && n < 10) begin step(1); n++; end
    en = 1'b0;
    step(6);
    chk("t4_reads", 64'(rdcnt - base), 64'd2);
    chk("t4_valid", 64'(m_valid), 64'd0);
    exp_wc += 2;
    drain("t4");
    f_clr = 1'b1; step(1); f_clr = 1'b0; step(1);

    // Random ready with concurrent writes of 0..99
    en = 1'b1; written = 0; n = 0;
    while ((written < 100 || exp_q.size() != 0) && n < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (written < 100 && $urandom_range(0, 1) == 1) begin
        w_en = 1'b1; w_data = DW'(written);
        exp_q.push_back(DW'(written));
        written++;
      end else begin
        w_en = 1'b0;
      end
      step(1); n++;
    end
    w_en = 1'b0; m_ready = 1'b1;
    exp_wc += 100;
    drain("t5");
    chk("t5_credit", 64'(credit_viol), 64'd0);

    // Reset mid-stream
    en = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(32'h30 + i), 1'b1);
    step(1);
    en = 1'b1;
    step(5);
    rst = 1'b1;
    step(1);
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_data", 64'(m_data), 64'd0);
    chk("t6_wc", 64'(wc), 64'd0);
    chk("t6_rden0", 64'(rd_en), 64'd0);
    exp_q.delete();
    step(1);
    chk("t6_rden1", 64'(rd_en), 64'd0);
    f_clr = 1'b1; step(1); f_clr = 1'b0;
    chk("t6_rden2", 64'(rd_en), 64'd0);
    rst = 1'b0;
    exp_wc = 0;
    step(2);
    push(32'h41, 1'b1);
    push(32'h42, 1'b1);
    exp_wc = 2;
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
